// File: rtl/ntt_sequencer.sv
// ntt_sequencer: read/twiddle/mode/write-address sequencer for one external butterfly over a coefficient-pair memory.
// Latency: first read one cycle after start; each write P=RD_LAT+BF_LAT cycles after its read; done one cycle after the last drain.
// Backpressure: none; one butterfly per ISSUE cycle, P-cycle drain between layers, abort flushes all pending writes.
module ntt_sequencer #(
    parameter int LOG_N  = 8,
    parameter int LAYERS = 7,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 4,
    parameter int AW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    src_base,
    input  logic [AW-1:0]    dst_base,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr_a,
    output logic [AW-1:0]    rd_addr_b,
    output logic [LOG_N-2:0] tw_idx,
    output logic             tw_neg,
    output logic [1:0]       bf_mode,
    output logic [2:0]       layer,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr_a,
    output logic [AW-1:0]    wr_addr_b
);
    localparam int P  = RD_LAT + BF_LAT;
    localparam int TW = LOG_N - 1;
    localparam int CW = $clog2(P + 1);
    localparam int KW = $clog2(LOG_N + 1);
    localparam logic [1:0] M_NTT  = 2'd0;
    localparam logic [1:0] M_INTT = 2'd1;
    localparam logic [1:0] M_PWM  = 2'd2;
    localparam logic [1:0] M_ILL  = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
    state_t state, state_nxt;

    logic [1:0]    mode_q;
    logic [AW-1:0] src_q, dst_q;
    logic          err_q;
    logic [TW-1:0] bfly;
    logic [CW-1:0] drain_cnt;
    logic          accept, abort_job, last_bfly, last_drain, last_layer;

    assign accept     = (state == IDLE) && start && !abort;
    assign abort_job  = (state != IDLE) && abort;
    assign last_bfly  = (bfly == {TW{1'b1}});
    assign last_drain = (drain_cnt == CW'(P - 1));
    assign last_layer = (mode_q == M_PWM) || (layer == 3'(LAYERS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: abort beats everything while busy; illegal mode goes straight to FIN
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start && !abort) state_nxt = (mode == M_ILL) ? FIN : ISSUE;
            ISSUE: if (abort) state_nxt = IDLE;
                   else if (last_bfly) state_nxt = DRAIN;
            DRAIN: if (abort) state_nxt = IDLE;
                   else if (last_drain) state_nxt = last_layer ? FIN : ISSUE;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job parameters latched at start, plus butterfly/drain/layer counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= M_NTT;
            src_q     <= '0;
            dst_q     <= '0;
            err_q     <= 1'b0;
            bfly      <= '0;
            drain_cnt <= '0;
            layer     <= '0;
        end else if (accept) begin
            if (mode != M_ILL) mode_q <= mode;
            src_q     <= src_base;
            dst_q     <= dst_base;
            err_q     <= (mode == M_ILL);
            bfly      <= '0;
            drain_cnt <= '0;
            layer     <= '0;
        end else if (state == ISSUE) begin
            bfly      <= bfly + 1'b1;
            drain_cnt <= '0;
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
            if (last_drain) begin
                drain_cnt <= '0;
                if (!last_layer) layer <= layer + 3'd1;
            end
        end
    end

    // Operand offsets: insert a zero bit at position log2(len) into b; PWM is the len=1 case
    logic [KW-1:0]    k;
    logic [LOG_N-1:0] b_ext, len_bit, a_off, b_off;
    logic [TW-1:0]    g, tw_calc;
    logic [AW-1:0]    rd_base;
    always_comb begin
        k = '0;
        if (mode_q == M_NTT)       k = KW'(LOG_N - 1 - int'(layer));
        else if (mode_q == M_INTT) k = KW'(int'(layer) + 1);
        b_ext   = {1'b0, bfly};
        len_bit = LOG_N'(1) << k;
        a_off   = ((b_ext >> k) << (k + 1'b1)) | (b_ext & (len_bit - LOG_N'(1)));
        b_off   = a_off | len_bit;
        g       = bfly >> k;
        // Twiddle arithmetic is modulo 2^TW; every legal result fits, so wrap of 2^(LAYERS-t) is harmless
        tw_calc = (TW'(1) << layer) + g;
        if (mode_q == M_INTT)     tw_calc = (TW'(1) << (3'(LAYERS) - layer)) - TW'(1) - g;
        else if (mode_q == M_PWM) tw_calc = (TW'(1) << 3'(LAYERS - 1)) + (bfly >> 1);
        rd_base = (layer == 3'd0) ? src_q : dst_q;
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign err       = (state == FIN) && err_q;
    assign rd_en     = (state == ISSUE);
    assign rd_addr_a = rd_en ? rd_base + AW'(a_off) : '0;
    assign rd_addr_b = rd_en ? rd_base + AW'(b_off) : '0;
    assign tw_idx    = rd_en ? tw_calc : '0;
    assign tw_neg    = rd_en && (mode_q == M_PWM) && bfly[0];
    assign bf_mode   = mode_q;

    logic [P-1:0]  pv;
    logic [AW-1:0] pa [P];
    logic [AW-1:0] pb [P];

    // Write-address delay line: each read's destination pair emerges exactly P cycles later
    always_ff @(posedge clk or posedge rst) begin
        if (rst || abort_job) begin
            pv <= '0;
            for (int i = 0; i < P; i++) begin
                pa[i] <= '0;
                pb[i] <= '0;
            end
        end else begin
            pv[0] <= rd_en;
            pa[0] <= rd_en ? dst_q + AW'(a_off) : '0;
            pb[0] <= rd_en ? dst_q + AW'(b_off) : '0;
            for (int i = 1; i < P; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
            end
        end
    end

    assign wr_en     = pv[P-1];
    assign wr_addr_a = pa[P-1];
    assign wr_addr_b = pb[P-1];
endmodule

// File: tb/tb_ntt_sequencer.sv
// Bench for ntt_sequencer: default 256-point instance plus a small LOG_N=4 instance.
// Per-cycle comparison against an arithmetic reference model, table of test-plan jobs with spot values.
// Random jobs (mode, bases, abort point) follow, then reset checks.
module tb_ntt_sequencer;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort, sel;
    logic [1:0] mode;
    logic [7:0] src_base, dst_base;
    logic       start_d, start_s;
    assign start_d = start & ~sel;
    assign start_s = start & sel;

    logic       d_busy, d_done, d_err, d_rd, d_neg, d_wr;
    logic [7:0] d_ra, d_rb, d_wa, d_wb;
    logic [6:0] d_tw;
    logic [1:0] d_md;
    logic [2:0] d_lay;
    logic       s_busy, s_done, s_err, s_rd, s_neg, s_wr;
    logic [4:0] s_ra, s_rb, s_wa, s_wb;
    logic [2:0] s_tw;
    logic [1:0] s_md;
    logic [2:0] s_lay;

    ntt_sequencer dut (
        .clk(clk), .rst(rst), .start(start_d), .abort(abort), .mode(mode),
        .src_base(src_base), .dst_base(dst_base),
        .busy(d_busy), .done(d_done), .err(d_err), .rd_en(d_rd),
        .rd_addr_a(d_ra), .rd_addr_b(d_rb), .tw_idx(d_tw), .tw_neg(d_neg),
        .bf_mode(d_md), .layer(d_lay), .wr_en(d_wr), .wr_addr_a(d_wa), .wr_addr_b(d_wb)
    );

    ntt_sequencer #(.LOG_N(4), .LAYERS(3), .RD_LAT(2), .BF_LAT(1), .AW(5)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .abort(abort), .mode(mode),
        .src_base(src_base[4:0]), .dst_base(dst_base[4:0]),
        .busy(s_busy), .done(s_done), .err(s_err), .rd_en(s_rd),
        .rd_addr_a(s_ra), .rd_addr_b(s_rb), .tw_idx(s_tw), .tw_neg(s_neg),
        .bf_mode(s_md), .layer(s_lay), .wr_en(s_wr), .wr_addr_a(s_wa), .wr_addr_b(s_wb)
    );

    logic       o_busy, o_done, o_err, o_rd, o_neg, o_wr;
    logic [7:0] o_ra, o_rb, o_wa, o_wb;
    logic [6:0] o_tw;
    logic [1:0] o_md;
    logic [2:0] o_lay;
    always_comb begin
        if (sel) begin
            o_busy = s_busy; o_done = s_done; o_err = s_err; o_rd = s_rd; o_neg = s_neg; o_wr = s_wr;
            o_ra = {3'b000, s_ra}; o_rb = {3'b000, s_rb}; o_wa = {3'b000, s_wa}; o_wb = {3'b000, s_wb};
            o_tw = {4'b0000, s_tw}; o_md = s_md; o_lay = s_lay;
        end else begin
            o_busy = d_busy; o_done = d_done; o_err = d_err; o_rd = d_rd; o_neg = d_neg; o_wr = d_wr;
            o_ra = d_ra; o_rb = d_rb; o_wa = d_wa; o_wb = d_wb;
            o_tw = d_tw; o_md = d_md; o_lay = d_lay;
        end
    end

    typedef struct {
        bit busy, done, err, rd, neg, wr;
        int ra, rb, tw, lay, md, wa, wb;
    } cyc_t;

    typedef struct {
        int sel, md, sb, db, ab, done_c, wr_n;
        int s1c, s1a, s1b, s1t, s1n;
        int s2c, s2a, s2b, s2t, s2n;
        int wc, wa, wb;
    } job_t;

    cyc_t em [MAXC];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: expected outputs for every cycle after start, from the length/group/twiddle rules
    task automatic build(input int md, input int sb, input int db, input int ab,
                         input int lgn, input int lay, input int p, input int aw,
                         output int end_c, output int eff_ab);
        int half, amask, nl, fin, c, len, g, j, a, tw;
        for (int i = 0; i < MAXC; i++) em[i] = '{default: 0};
        half  = 1 << (lgn - 1);
        amask = (1 << aw) - 1;
        if (md == 3) begin
            fin = 1;
            em[1].busy = 1; em[1].done = 1; em[1].err = 1;
        end else begin
            nl = (md == 2) ? 1 : lay;
            for (int l = 0; l < nl; l++) begin
                for (int b = 0; b < half; b++) begin
                    c = 1 + l * (half + p) + b;
                    if (md == 0) begin
                        len = (1 << lgn) >> (l + 1);
                        g = b / len; j = b % len; a = 2 * g * len + j;
                        tw = (1 << l) + g;
                    end else if (md == 1) begin
                        len = 2 << l;
                        g = b / len; j = b % len; a = 2 * g * len + j;
                        tw = (1 << (lay - l)) - 1 - g;
                    end else begin
                        len = 1; a = 2 * b;
                        tw = (1 << (lay - 1)) + b / 2;
                    end
                    em[c].rd  = 1;
                    em[c].ra  = (((l == 0) ? sb : db) + a) & amask;
                    em[c].rb  = (((l == 0) ? sb : db) + a + len) & amask;
                    em[c].tw  = tw;
                    em[c].neg = (md == 2) && (b % 2 == 1);
                    em[c].lay = l;
                    em[c].md  = md;
                    em[c+p].wr = 1;
                    em[c+p].wa = (db + a) & amask;
                    em[c+p].wb = (db + a + len) & amask;
                end
            end
            fin = nl * (half + p) + 1;
            for (int i = 1; i <= fin; i++) em[i].busy = 1;
            em[fin].done = 1;
        end
        eff_ab = (ab > 0 && ab < fin) ? ab : 0;
        if (eff_ab > 0) begin
            for (int i = eff_ab + 1; i < MAXC; i++) em[i] = '{default: 0};
            end_c = eff_ab + 1;
        end else begin
            end_c = fin + 1;
        end
    endtask

    task automatic check_cycle(input int c, input int id);
        cyc_t e;
        bit ok;
        e = em[c];
        ok = (o_busy == e.busy) && (o_done == e.done) && (o_err == e.err) && (o_rd == e.rd) && (o_wr == e.wr);
        if (e.rd) ok = ok && (int'(o_ra) == e.ra) && (int'(o_rb) == e.rb) && (int'(o_tw) == e.tw)
                          && (o_neg == e.neg) && (int'(o_lay) == e.lay) && (int'(o_md) == e.md);
        if (e.wr) ok = ok && (int'(o_wa) == e.wa) && (int'(o_wb) == e.wb);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL cycle job%0d c%0d got busy%0b done%0b err%0b rd%0b a%0h b%0h tw%0d neg%0b L%0d m%0d wr%0b wa%0h wb%0h want busy%0b done%0b err%0b rd%0b a%0h b%0h tw%0d neg%0b L%0d m%0d wr%0b wa%0h wb%0h",
                     id, c, o_busy, o_done, o_err, o_rd, o_ra, o_rb, o_tw, o_neg, o_lay, o_md, o_wr, o_wa, o_wb,
                     e.busy, e.done, e.err, e.rd, e.ra, e.rb, e.tw, e.neg, e.lay, e.md, e.wr, e.wa, e.wb);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_zero(input string name);
        bit ok;
        ok = !o_busy && !o_done && !o_err && !o_rd && !o_neg && !o_wr && o_ra == 0 && o_rb == 0
             && o_wa == 0 && o_wb == 0 && o_tw == 0 && o_md == 0 && o_lay == 0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s got busy%0b done%0b err%0b rd%0b wr%0b a%0h b%0h tw%0d wa%0h wb%0h m%0d L%0d want all zero",
                     name, o_busy, o_done, o_err, o_rd, o_wr, o_ra, o_rb, o_tw, o_wa, o_wb, o_md, o_lay);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge (edge 0)
    task automatic run_job(input job_t jv, input int id);
        int end_c, eff_ab, done_c, wr_n;
        if (jv.sel == 0) build(jv.md, jv.sb, jv.db, jv.ab, 8, 7, 5, 8, end_c, eff_ab);
        else             build(jv.md, jv.sb, jv.db, jv.ab, 4, 3, 3, 5, end_c, eff_ab);
        done_c = 0;
        wr_n   = 0;
        sel      = (jv.sel != 0);
        start    = 1'b1;
        abort    = 1'b0;
        mode     = 2'(jv.md);
        src_base = 8'(jv.sb);
        dst_base = 8'(jv.db);
        for (int c = 1; c <= end_c; c++) begin
            @(negedge clk);
            check_cycle(c, id);
            if (o_done && done_c == 0) done_c = c;
            if (o_wr) wr_n++;
            if (c == jv.s1c) begin
                check_int($sformatf("job%0d spot1 rd_addr_a", id), int'(o_ra), jv.s1a);
                check_int($sformatf("job%0d spot1 rd_addr_b", id), int'(o_rb), jv.s1b);
                check_int($sformatf("job%0d spot1 tw_idx/neg", id), int'(o_tw) * 2 + int'(o_neg), jv.s1t * 2 + jv.s1n);
            end
            if (c == jv.s2c) begin
                check_int($sformatf("job%0d spot2 rd_addr_a", id), int'(o_ra), jv.s2a);
                check_int($sformatf("job%0d spot2 rd_addr_b", id), int'(o_rb), jv.s2b);
                check_int($sformatf("job%0d spot2 tw_idx/neg", id), int'(o_tw) * 2 + int'(o_neg), jv.s2t * 2 + jv.s2n);
            end
            if (c == jv.wc) begin
                check_int($sformatf("job%0d spot wr_addr_a", id), int'(o_wa), jv.wa);
                check_int($sformatf("job%0d spot wr_addr_b", id), int'(o_wb), jv.wb);
            end
            // Stray start in cycle 1 must be ignored; inputs change freely after start
            start    = (c == 1);
            mode     = 2'($urandom_range(0, 3));
            src_base = 8'($urandom_range(0, 255));
            dst_base = 8'($urandom_range(0, 255));
            abort    = (c == eff_ab);
        end
        start = 1'b0;
        abort = 1'b0;
        if (jv.done_c >= 0) begin
            check_int($sformatf("job%0d done cycle", id), done_c, jv.done_c);
            check_int($sformatf("job%0d wr_en count", id), wr_n, jv.wr_n);
        end
    endtask

    initial begin
        job_t jobs [8];
        job_t r;
        jobs[0] = '{0, 0, 'h00, 'h80, 0, 932, 896, 1, 'h00, 'h80, 1, 0, 799, 'h80, 'h82, 64, 0, 6, 'h80, 'h00};
        jobs[1] = '{0, 1, 'h00, 'h00, 0, 932, 896, 2, 'h01, 'h03, 127, 0, 134, 'h00, 'h04, 63, 0, 6, 'h00, 'h02};
        jobs[2] = '{0, 2, 'h00, 'hF0, 0, 134, 128, 4, 'h06, 'h07, 65, 1, 1, 'h00, 'h01, 64, 0, 14, 'h00, 'h01};
        jobs[3] = '{0, 3, 'h12, 'h34, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        jobs[4] = '{0, 0, 'h11, 'h80, 50, 0, 45, 1, 'h11, 'h91, 1, 0, 0, 0, 0, 0, 0, 6, 'h80, 'h00};
        jobs[5] = '{0, 0, 'h40, 'h80, 0, 932, 896, 1, 'h40, 'hC0, 1, 0, 134, 'h80, 'hC0, 2, 0, 6, 'h80, 'h00};
        jobs[6] = '{1, 0, 'h00, 'h1C, 0, 34, 24, 1, 'h00, 'h08, 1, 0, 12, 'h1C, 'h00, 2, 0, 4, 'h1C, 'h04};
        jobs[7] = '{1, 1, 'h03, 'h05, 0, 34, 24, 1, 'h03, 'h05, 7, 0, 0, 0, 0, 0, 0, 4, 'h05, 'h07};

        rst = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0; mode = 2'd0; src_base = 8'h00; dst_base = 8'h00;
        repeat (2) @(negedge clk);
        check_zero("reset default");
        sel = 1'b1;
        #1 check_zero("reset small");
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_job(jobs[i], i);

        for (int k = 0; k < 12; k++) begin
            r = jobs[0];
            r.sel = (k < 3) ? 0 : 1;
            r.md  = $urandom_range(0, 3);
            r.sb  = $urandom_range(0, 255);
            r.db  = $urandom_range(0, 255);
            r.ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 40) : 0;
            r.done_c = -1;
            r.s1c = 0; r.s2c = 0; r.wc = 0;
            run_job(r, 100 + k);
        end

        // Reset in the middle of a job discards everything
        sel = 1'b0; start = 1'b1; mode = 2'd0; src_base = 8'h00; dst_base = 8'h80;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        #1 check_zero("mid-job reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_int($sformatf("post-reset idle %0d", i), int'(o_busy) + int'(o_wr) + int'(o_rd), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
